// File: rtl/dom_rand_pkg.sv
// rtl/dom_rand_pkg.sv - shared widths, LFSR taps and FSM encoding for the DOM randomness source
package dom_rand_pkg;

    // Fibonacci taps of the 32-bit LFSR: fb = s[31]^s[21]^s[1]^s[0]
    localparam int LFSR_TAP_A = 31;
    localparam int LFSR_TAP_B = 21;
    localparam int LFSR_TAP_C = 1;
    localparam int LFSR_TAP_D = 0;

    typedef enum logic [1:0] {
        ST_UNSEEDED = 2'd0,
        ST_LOAD     = 2'd1,
        ST_RUN      = 2'd2
    } dom_rand_state_e;

    // Remask bits per DOM multiplier instance
    function automatic int z_bits(input int shares);
        return shares * (shares - 1);
    endfunction

    // Blinding bits per multiplier; the first-order two-share variant needs only one GF(2^2) element
    function automatic int b_bits(input int shares, input int firstOrderOpt);
        return (firstOrderOpt == 1 && shares == 2) ? 2 : 2 * shares;
    endfunction

endpackage

// File: rtl/dom_rand_source_if.sv
// rtl/dom_rand_source_if.sv - seed handshake and randomness bundle of dom_rand_source
interface dom_rand_source_if #(
    parameter int ZW = 2,
    parameter int BW = 2
);
    logic          SeedStartxSI;
    logic [7:0]    SeedxDI;
    logic          SeedValidxSI;
    logic          SeedReadyxSO;
    logic          EnxSI;
    logic [ZW-1:0] _Z1xDO;
    logic [ZW-1:0] _Z2xDO;
    logic [BW-1:0] _BxDO;
    logic          RandValidxSO;
    logic          ReseedReqxSO;

    modport master (
        output SeedStartxSI, SeedxDI, SeedValidxSI, EnxSI,
        input  SeedReadyxSO, _Z1xDO, _Z2xDO, _BxDO, RandValidxSO, ReseedReqxSO
    );

    modport slave (
        input  SeedStartxSI, SeedxDI, SeedValidxSI, EnxSI,
        output SeedReadyxSO, _Z1xDO, _Z2xDO, _BxDO, RandValidxSO, ReseedReqxSO
    );
endinterface

// File: rtl/dom_lfsr_step.sv
// rtl/dom_lfsr_step.sv - combinational RAND_BITS-step advance of the 32-bit LFSR
module dom_lfsr_step
    import dom_rand_pkg::*;
#(
    parameter int RAND_BITS = 6
) (
    input  logic [31:0]          StatexDI,
    output logic [31:0]          StatexDO,
    output logic [RAND_BITS-1:0] BitsxDO
);

    logic [31:0] stateW;

    // Unrolled shift chain; feedback of step k becomes output bit k
    always_comb begin
        stateW  = StatexDI;
        BitsxDO = '0;
        for (int k = 0; k < RAND_BITS; k++) begin
            BitsxDO[k] = stateW[LFSR_TAP_A] ^ stateW[LFSR_TAP_B] ^ stateW[LFSR_TAP_C] ^ stateW[LFSR_TAP_D];
            stateW     = {stateW[30:0], BitsxDO[k]};
        end
        StatexDO = stateW;
    end

endmodule

// File: rtl/dom_rand_source.sv
// rtl/dom_rand_source.sv - seeded LFSR randomness source for paired DOM multipliers (option: DOM_RAND_ZERO_EN)
module dom_rand_source
    import dom_rand_pkg::*;
#(
    parameter int SHARES                   = 2,
    parameter int FIRST_ORDER_OPTIMIZATION = 1,
    parameter int N_MULS                   = 1,
    parameter int RESEED_INTERVAL          = 1048576
) (
    input  logic               ClkxCI,
    input  logic               RstxRI,
    dom_rand_source_if.slave   rif
);

    localparam int Z_BITS    = z_bits(SHARES);
    localparam int B_BITS    = b_bits(SHARES, FIRST_ORDER_OPTIMIZATION);
    localparam int P_BITS    = 2 * Z_BITS + B_BITS;
    localparam int RAND_BITS = N_MULS * P_BITS;
    localparam logic [31:0] RESEED_CNT = 32'(RESEED_INTERVAL);

    if (RAND_BITS > 32) begin : g_rand_bits_check
        $error("dom_rand_source: RAND_BITS exceeds the 32-bit LFSR");
    end

    dom_rand_state_e        stateQ, stateD;
    logic [1:0]             byteCntQ;
    logic [31:0]            lfsrQ, lfsrStepD, seedD;
    logic [31:0]            useCntQ;
    logic [RAND_BITS-1:0]   stepBits, randQ, randOut;
    logic                   randValidQ;
    logic                   seedReady, loadBeat, lastBeat, stepEn, enterLoad;

    dom_lfsr_step #(.RAND_BITS(RAND_BITS)) u_step (
        .StatexDI (lfsrQ),
        .StatexDO (lfsrStepD),
        .BitsxDO  (stepBits)
    );

    // FSM state register
    always_ff @(posedge ClkxCI or posedge RstxRI) begin
        if (RstxRI) stateQ <= ST_UNSEEDED;
        else        stateQ <= stateD;
    end

    // FSM next state; a start request outranks stepping in RUN and is ignored in LOAD
    always_comb begin
        stateD = stateQ;
        case (stateQ)
            ST_UNSEEDED: if (rif.SeedStartxSI) stateD = ST_LOAD;
            ST_LOAD:     if (rif.SeedValidxSI && byteCntQ == 2'd3) stateD = ST_RUN;
            ST_RUN:      if (rif.SeedStartxSI) stateD = ST_LOAD;
            default:     stateD = ST_UNSEEDED;
        endcase
    end

    // FSM outputs and datapath strobes
    always_comb begin
        seedReady = (stateQ == ST_LOAD);
        loadBeat  = seedReady && rif.SeedValidxSI;
        lastBeat  = loadBeat && (byteCntQ == 2'd3);
        stepEn    = (stateQ == ST_RUN) && rif.EnxSI && !rif.SeedStartxSI;
        enterLoad = (stateD == ST_LOAD) && (stateQ != ST_LOAD);
    end

    // Seed byte placement; an all-zero seed would lock the LFSR, so bit 0 is forced on the last beat
    always_comb begin
        seedD = lfsrQ;
        seedD[{byteCntQ, 3'b000} +: 8] = rif.SeedxDI;
        if (lastBeat && seedD == 32'd0) seedD[0] = 1'b1;
    end

    // LFSR state and seed byte counter
    always_ff @(posedge ClkxCI or posedge RstxRI) begin
        if (RstxRI) begin
            lfsrQ    <= '0;
            byteCntQ <= '0;
        end else if (enterLoad) begin
            byteCntQ <= '0;
        end else if (loadBeat) begin
            lfsrQ    <= seedD;
            byteCntQ <= byteCntQ + 2'd1;
        end else if (stepEn) begin
            lfsrQ    <= lfsrStepD;
        end
    end

    // Output registers; held when not enabled, cleared whenever a new seed load begins
    always_ff @(posedge ClkxCI or posedge RstxRI) begin
        if (RstxRI) begin
            randQ      <= '0;
            randValidQ <= 1'b0;
        end else if (enterLoad) begin
            randQ      <= '0;
            randValidQ <= 1'b0;
        end else if (stepEn) begin
            randQ      <= stepBits;
            randValidQ <= 1'b1;
        end
    end

    // Saturating usage counter, restarted by each completed seed load
    always_ff @(posedge ClkxCI or posedge RstxRI) begin
        if (RstxRI)                              useCntQ <= '0;
        else if (lastBeat)                       useCntQ <= '0;
        else if (stepEn && useCntQ != RESEED_CNT) useCntQ <= useCntQ + 32'd1;
    end

`ifdef DOM_RAND_ZERO_EN
    assign randOut = '0;
`else
    assign randOut = randQ;
`endif

    for (genvar m = 0; m < N_MULS; m++) begin : g_pack
        assign rif._Z1xDO[m*Z_BITS +: Z_BITS] = randOut[m*P_BITS +: Z_BITS];
        assign rif._Z2xDO[m*Z_BITS +: Z_BITS] = randOut[m*P_BITS + Z_BITS +: Z_BITS];
        assign rif._BxDO[m*B_BITS +: B_BITS]  = randOut[m*P_BITS + 2*Z_BITS +: B_BITS];
    end

    assign rif.SeedReadyxSO = seedReady;
    assign rif.RandValidxSO = randValidQ;
    assign rif.ReseedReqxSO = (useCntQ == RESEED_CNT);

endmodule

// File: tb/tb_dom_rand_source.sv
// tb/tb_dom_rand_source.sv - randomized self-checking bench for dom_rand_source
module tb_dom_rand_source;

    localparam int RESEED = 4;

    logic ClkxCI = 1'b0;
    logic RstxRI = 1'b1;

    always #5 ClkxCI = ~ClkxCI;

    dom_rand_source_if #(.ZW(2), .BW(2)) rif ();

    dom_rand_source #(
        .SHARES                   (2),
        .FIRST_ORDER_OPTIMIZATION (1),
        .N_MULS                   (1),
        .RESEED_INTERVAL          (RESEED)
    ) dut (
        .ClkxCI (ClkxCI),
        .RstxRI (RstxRI),
        .rif    (rif)
    );

    int checks = 0;
    int passes = 0;

    // Reference model: LFSR value, last emitted bits, valid flag, usage count
    logic [31:0] mS;
    logic [5:0]  mOut;
    logic        mValid;
    int          mCnt;

    task automatic tick();
        @(posedge ClkxCI);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Compares {RandValid, ReseedReq, B, Z2, Z1} against the model
    task automatic check_model(input string tag);
        check(tag,
              32'({rif.RandValidxSO, rif.ReseedReqxSO, rif._BxDO, rif._Z2xDO, rif._Z1xDO}),
              32'({mValid, (mCnt == RESEED), mOut}));
    endtask

    // One enabled step: six feedback bits, output bit k is the feedback of step k
    task automatic model_step();
        logic [5:0] b;
        logic       fb;
        for (int k = 0; k < 6; k++) begin
            fb   = ^(mS & 32'h8020_0003);
            mS   = (mS << 1) | 32'(fb);
            b[k] = fb;
        end
        mOut   = b;
        mValid = 1'b1;
        if (mCnt < RESEED) mCnt++;
    endtask

    task automatic model_seed(input logic [31:0] seed);
        mS   = (seed == 32'd0) ? 32'd1 : seed;
        mCnt = 0;
    endtask

    task automatic start_load();
        rif.SeedStartxSI = 1'b1;
        tick();
        rif.SeedStartxSI = 1'b0;
        mOut   = '0;
        mValid = 1'b0;
        check("ready_in_load", 32'(rif.SeedReadyxSO), 32'd1);
        check_model("enter_load");
    endtask

    task automatic load_seed(input logic [31:0] seed);
        start_load();
        for (int k = 0; k < 4; k++) begin
            rif.SeedxDI      = seed[8*k +: 8];
            rif.SeedValidxSI = 1'b1;
            tick();
        end
        rif.SeedValidxSI = 1'b0;
        model_seed(seed);
        check("ready_after_load", 32'(rif.SeedReadyxSO), 32'd0);
    endtask

    task automatic step_check(input string tag);
        rif.EnxSI = 1'b1;
        tick();
        rif.EnxSI = 1'b0;
        model_step();
        check_model(tag);
    endtask

    initial begin
        logic [31:0] seed;
        int          beats;
        int          guard;
        logic        v;

        rif.SeedStartxSI = 1'b0;
        rif.SeedxDI      = 8'h00;
        rif.SeedValidxSI = 1'b0;
        rif.EnxSI        = 1'b0;
        mS = '0; mOut = '0; mValid = 1'b0; mCnt = 0;

        // 1. reset state, then enable while unseeded
        #2;
        check_model("reset_outputs");
        check("reset_ready", 32'(rif.SeedReadyxSO), 32'd0);
        tick(); tick();
        RstxRI    = 1'b0;
        rif.EnxSI = 1'b1;
        repeat (3) tick();
        rif.EnxSI = 1'b0;
        check_model("unseeded_en");
        check("unseeded_ready", 32'(rif.SeedReadyxSO), 32'd0);

        // 2. seed 0x00000001, one step
        load_seed(32'h0000_0001);
        step_check("seed1_model");
        check("seed1_bits", 32'({rif._BxDO, rif._Z2xDO, rif._Z1xDO}), 32'h2D);

        // 3. all-zero seed behaves as seed 1
        load_seed(32'h0000_0000);
        step_check("seed0_model");
        check("seed0_bits", 32'({rif._BxDO, rif._Z2xDO, rif._Z1xDO}), 32'h2D);

        // 4. gapped seed load with random valid pattern
        seed = $urandom;
        start_load();
        beats = 0;
        guard = 0;
        while (beats < 4 && guard < 200) begin
            v = 1'($urandom_range(0, 1));
            check("gap_ready", 32'(rif.SeedReadyxSO), 32'd1);
            rif.SeedValidxSI = v;
            rif.SeedxDI      = v ? seed[8*beats +: 8] : 8'($urandom);
            tick();
            if (v) beats++;
            guard++;
            if (beats < 4) check_model("gap_in_load");
        end
        rif.SeedValidxSI = 1'b0;
        check("gap_beats", 32'(beats), 32'd4);
        check("gap_ready_after", 32'(rif.SeedReadyxSO), 32'd0);
        model_seed(seed);

        // random enable run against the model, crossing the reseed threshold
        for (int i = 0; i < 30; i++) begin
            v = 1'($urandom_range(0, 1));
            rif.EnxSI = v;
            tick();
            if (v) model_step();
            check_model("rand_run");
        end
        rif.EnxSI = 1'b0;

        // 5. reseed request rises after step 4 and stays; a new seed clears it
        load_seed($urandom);
        for (int i = 1; i <= 5; i++) begin
            step_check("reseed_step");
            check("reseed_req", 32'(rif.ReseedReqxSO), (i >= RESEED) ? 32'd1 : 32'd0);
        end
        load_seed($urandom);
        check("reseed_cleared", 32'(rif.ReseedReqxSO), 32'd0);
        step_check("after_reseed");

        // 6. start and enable together in RUN: load wins, outputs cleared
        rif.SeedStartxSI = 1'b1;
        rif.EnxSI        = 1'b1;
        tick();
        rif.SeedStartxSI = 1'b0;
        rif.EnxSI        = 1'b0;
        mOut   = '0;
        mValid = 1'b0;
        check("start_en_ready", 32'(rif.SeedReadyxSO), 32'd1);
        check_model("start_en");

        // asynchronous reset in the middle of a load
        for (int k = 0; k < 2; k++) begin
            rif.SeedxDI      = 8'($urandom);
            rif.SeedValidxSI = 1'b1;
            tick();
        end
        rif.SeedValidxSI = 1'b0;
        #2;
        RstxRI = 1'b1;
        #1;
        mOut = '0; mValid = 1'b0; mCnt = 0;
        check_model("async_rst");
        check("async_rst_ready", 32'(rif.SeedReadyxSO), 32'd0);
        tick();
        RstxRI    = 1'b0;
        rif.EnxSI = 1'b1;
        repeat (2) tick();
        rif.EnxSI = 1'b0;
        check_model("rst_discards_seed");

        // fresh seed after reset still matches the model
        load_seed($urandom);
        for (int i = 0; i < 3; i++) step_check("final_run");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/dom_rand_source.md
Name: dom_rand_source

Overview:
- Fresh-randomness transmitter for the paired DOM GF(2^2) multipliers in the masked AES S-box.
- Produces the per-cycle remask values Z1, Z2 and blinding value B those multipliers consume, from a seeded 32-bit LFSR.
- Seed is loaded through a byte-wide valid/ready handshake; the block tracks usage and requests reseeding.

Parameters:
- SHARES, 2, number of shares per masked value.
- FIRST_ORDER_OPTIMIZATION, 1, selects the first-order B width when SHARES==2.
- N_MULS, 1, number of paired multipliers fed per cycle.
- RESEED_INTERVAL, 1048576, steps after which ReseedReqxSO asserts.

Ports:
- ClkxCI  in  1  clock, rising edge.
- RstxRI  in  1  asynchronous reset, active-high.
- SeedStartxSI  in  1  pulse: enter seed load.
- SeedxDI  in  8  seed byte.
- SeedValidxSI  in  1  seed byte valid.
- SeedReadyxSO  out  1  seed byte accepted when high with valid.
- EnxSI  in  1  step LFSR, emit new randomness this edge.
- _Z1xDO  out  N_MULS*Z_BITS  remask for multiplier instance 1.
- _Z2xDO  out  N_MULS*Z_BITS  remask for multiplier instance 2.
- _BxDO  out  N_MULS*B_BITS  blinding value.
- RandValidxSO  out  1  outputs hold fresh, seeded randomness.
- ReseedReqxSO  out  1  usage count reached RESEED_INTERVAL.

Behaviour:
- Widths:
  - Z_BITS = SHARES*(SHARES-1).
  - B_BITS = 2 if FIRST_ORDER_OPTIMIZATION==1 && SHARES==2, else 2*SHARES.
  - RAND_BITS = N_MULS*(2*Z_BITS+B_BITS). RAND_BITS > 32 is an elaboration error.
- Reset (async, RstxRI=1):
  - state=UNSEEDED, LFSR=0, byte counter=0, usage counter=0.
  - All data outputs 0; RandValidxSO, SeedReadyxSO and ReseedReqxSO are 0.
- FSM: UNSEEDED, LOAD, RUN.
  - UNSEEDED: SeedStartxSI -> LOAD.
  - LOAD:
    - SeedReadyxSO=1. Each handshake shifts the byte in; beat k fills LFSR[8k+7:8k], k=0..3.
    - The 4th beat moves the FSM to RUN on the same edge.
    - If the assembled seed is all-zero, LFSR bit0 is forced to 1.
    - SeedStartxSI is ignored in LOAD.
    - Entering LOAD clears RandValidxSO and zeroes the data outputs.
  - RUN:
    - SeedStartxSI has priority over EnxSI: it moves to LOAD with byte counter 0, and the LFSR is not stepped.
    - Completing a seed load clears the usage counter and ReseedReqxSO.
- LFSR step, repeated RAND_BITS times combinationally per enabled edge:
  - fb = s[31]^s[21]^s[1]^s[0]; s <= {s[30:0], fb}.
  - The fb of step k is output bit k (bit 0 first).
- Output packing: for multiplier m, bits [m*P +: P] with P = 2*Z_BITS+B_BITS. Within each slice, Z1 takes the low Z_BITS, then Z2, then B.
- Timing:
  - In RUN with EnxSI=1, the output registers load the new bits at the edge. RandValidxSO=1 from the edge after the first enabled step.
  - EnxSI=0 holds both LFSR and outputs; the consumer must not reuse held values.
- Usage counter:
  - 32-bit; increments per enabled step and saturates at RESEED_INTERVAL.
  - ReseedReqxSO=1 while the counter equals RESEED_INTERVAL.
  - Operation continues after the request.
- Reset mid-load or mid-run returns to the reset state immediately; a partial seed is discarded.

Optional Feature:
- DOM_RAND_ZERO_EN defined: _Z1xDO, _Z2xDO and _BxDO are tied to 0. The FSM, handshake, RandValidxSO and counter are unchanged. Used for functional debug of the unmasked datapath.
- Undefined: normal LFSR outputs.

Decomposition:
- Shared package dom_rand_pkg:
  - Z_BITS/B_BITS width functions, shared with the multiplier's blind-count function.
  - LFSR tap constants.
  - FSM state encoding.
- Natural sub-module: dom_lfsr_step, a combinational N-step LFSR advance returning the next state and RAND_BITS output bits.

Test Plan:
1. Reset then idle, EnxSI=1 -> all outputs 0, RandValidxSO=0, state UNSEEDED.
2. SeedStartxSI pulse, beats 0x01,0x00,0x00,0x00, then one EnxSI cycle (defaults) -> _Z1xDO=2'b01, _Z2xDO=2'b11, _BxDO=2'b10, LFSR=0x0000006D, RandValidxSO=1.
3. Seed all-zero (four 0x00 beats) -> identical result to scenario 2.
4. SeedValidxSI toggled with gaps during load -> exactly 4 beats accepted; RUN entered only after the 4th.
5. RESEED_INTERVAL=4, 5 enabled steps -> ReseedReqxSO rises after step 4 and stays high; reseed completion clears it.
6. SeedStartxSI and EnxSI both high in RUN -> LFSR unchanged, RandValidxSO=0, SeedReadyxSO=1 next cycle; RstxRI mid-load -> all outputs 0 asynchronously.
